// File: rtl/quad_decoder.sv
// Quadrature rotary-encoder decoder: two-flop synchroniser, per-phase debounce,
// Gray-code step decode with illegal-jump flagging, and a start-up priming window.
module quad_decoder #(
  parameter int dbw = 4,
  parameter bit x4  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a,
  input  logic       b,
  output logic       ena,
  output logic       dir,
  output logic       err,
  output logic [1:0] state
);

  localparam int               INIT_W    = dbw + 1;
  localparam logic [dbw-1:0]   CNT_ONE   = dbw'(1);
  localparam logic [dbw-1:0]   CNT_MAX   = '1;
  localparam logic [INIT_W-1:0] INIT_ONE  = INIT_W'(1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'((1 << dbw) + 1);

  // Modular distance between Gray positions gives the step kind directly.
  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_ERR  = 2'd2,
    STEP_DOWN = 2'd3
  } step_e;

  logic [1:0]            sync1_q, sync1_d;
  logic [1:0]            sx_q, sx_d;
  logic [1:0]            deb_q, deb_d;
  logic [1:0]            prev_q, prev_d;
  logic [1:0][dbw-1:0]   cnt_q, cnt_d;
  logic [INIT_W-1:0]     init_cnt_q, init_cnt_d;
  logic                  primed_q, primed_d;
  logic                  ena_q, ena_d;
  logic                  dir_q, dir_d;
  logic                  err_q, err_d;
  step_e                 step;

  function automatic logic [1:0] gray2bin(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  always_comb begin : sync_next
    sync1_d = {a, b};
    sx_d    = sync1_q;
  end

  always_comb begin : debounce_next
    // NOTE: every variable gets a default first so no path can infer a latch.
    deb_d      = deb_q;
    cnt_d      = cnt_q;
    init_cnt_d = init_cnt_q;
    primed_d   = primed_q;
    if (!primed_q) begin
      // Track the pins directly so an encoder resting off 00 does not strobe.
      deb_d = sx_q;
      cnt_d = '0;
      if (init_cnt_q == INIT_LAST) primed_d = 1'b1;
      else                         init_cnt_d = init_cnt_q + INIT_ONE;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sx_q[i] == deb_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] != CNT_MAX) begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end else begin
          deb_d[i] = sx_q[i];
          cnt_d[i] = '0;
        end
      end
    end
  end

  always_comb begin : decode_next
    step   = step_e'(gray2bin(deb_q) - gray2bin(prev_q));
    prev_d = deb_q;
    ena_d  = 1'b0;
    err_d  = 1'b0;
    dir_d  = dir_q;
    if (primed_q) begin
      unique case (step)
        STEP_UP: begin
          if (x4 || deb_q == 2'b00) begin
            ena_d = 1'b1;
            dir_d = 1'b1;
          end
        end
        STEP_DOWN: begin
          if (x4 || deb_q == 2'b00) begin
            ena_d = 1'b1;
            dir_d = 1'b0;
          end
        end
        STEP_ERR: err_d = 1'b1;
        default:  ;
      endcase
    end
  end

  // NOTE: all state is small control logic, so every flop is cleared on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= '0;
      sx_q       <= '0;
      deb_q      <= '0;
      prev_q     <= '0;
      cnt_q      <= '0;
      init_cnt_q <= '0;
      primed_q   <= 1'b0;
      ena_q      <= 1'b0;
      dir_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      sync1_q    <= sync1_d;
      sx_q       <= sx_d;
      deb_q      <= deb_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      init_cnt_q <= init_cnt_d;
      primed_q   <= primed_d;
      ena_q      <= ena_d;
      dir_q      <= dir_d;
      err_q      <= err_d;
    end
  end

  assign ena   = ena_q;
  assign dir   = dir_q;
  assign err   = err_q;
  assign state = deb_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: one x4 instance and one per-detent instance
// share the same pins; strobes are logged and compared with hand-derived values.
module tb_quad_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       a, b;
  logic       ena4, dir4, err4;
  logic [1:0] st4;
  logic       ena1, dir1, err1;
  logic [1:0] st1;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0;
  int n_ena4 = 0, n_err4 = 0, n_ena1 = 0, n_err1 = 0, wide4 = 0, wide1 = 0;
  logic ena4_d = 1'b0, ena1_d = 1'b0;
  int   ena4_cyc[$];
  logic ena4_dir[$];
  int   ena1_cyc[$];
  logic ena1_dir[$];
  logic [1:0] ena1_st[$];
  int   ud_count = 0;

  quad_decoder #(.dbw(4), .x4(1'b1)) u_dut4 (
    .clk(clk), .reset(reset), .a(a), .b(b),
    .ena(ena4), .dir(dir4), .err(err4), .state(st4)
  );

  quad_decoder #(.dbw(4), .x4(1'b0)) u_dut1 (
    .clk(clk), .reset(reset), .a(a), .b(b),
    .ena(ena1), .dir(dir1), .err(err1), .state(st1)
  );

  always #5 clk = ~clk;

  // Up/down parameter counter driven by the per-detent instance.
  always @(posedge clk) begin
    if (ena1) ud_count <= dir1 ? ud_count + 1 : ud_count - 1;
  end

  // Strobe logger, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (ena4) begin
      n_ena4++;
      ena4_cyc.push_back(cyc);
      ena4_dir.push_back(dir4);
    end
    if (ena1) begin
      n_ena1++;
      ena1_cyc.push_back(cyc);
      ena1_dir.push_back(dir1);
      ena1_st.push_back(st1);
    end
    if (err4) n_err4++;
    if (err1) n_err1++;
    if (ena4 && ena4_d) wide4++;
    if (ena1 && ena1_d) wide1++;
    ena4_d = ena4;
    ena1_d = ena1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int q4_cyc(input int idx);
    return (idx < ena4_cyc.size()) ? ena4_cyc[idx] : -1;
  endfunction

  function automatic int q1_cyc(input int idx);
    return (idx < ena1_cyc.size()) ? ena1_cyc[idx] : -1;
  endfunction

  // Drive {a,b} on a falling edge and hold it for n cycles; returns change cycle.
  task automatic hold(input logic [1:0] ab, input int n, output int chg);
    {a, b} = ab;
    chg = cyc;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int chg;
    int chgs[4];
    int b4, b1, e4, e1, ee4, ee1, base_ud;
    logic [1:0] cw[4];
    logic [1:0] ccw[4];
    cw[0] = 2'b01; cw[1] = 2'b11; cw[2] = 2'b10; cw[3] = 2'b00;
    ccw[0] = 2'b10; ccw[1] = 2'b11; ccw[2] = 2'b01; ccw[3] = 2'b00;

    // Reset with the encoder resting at 11.
    reset = 1'b0;
    a = 1'b1;
    b = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ena", ena4, 1'b0);
    check("rst_err", err4, 1'b0);
    check("rst_dir", dir4, 1'b0);
    check("rst_state", st4, 2'b00);

    // Init path: state follows pins, no strobes.
    reset = 1'b1;
    repeat (18) @(negedge clk);
    check("init_state4", st4, 2'b11);
    check("init_state1", st1, 2'b11);
    repeat (82) @(negedge clk);
    check("idle_ena4", n_ena4, 0);
    check("idle_err4", n_err4, 0);
    check("idle_ena1", n_ena1, 0);
    check("idle_err1", n_err1, 0);

    // Both phases flip together 11 -> 00: illegal jump.
    e4 = n_ena4; ee4 = n_err4; ee1 = n_err1;
    hold(2'b00, 40, chg);
    check("jump_err4", n_err4 - ee4, 1);
    check("jump_err1", n_err1 - ee1, 1);
    check("jump_ena4", n_ena4 - e4, 0);
    check("jump_dir4", dir4, 1'b0);
    check("jump_state", st4, 2'b00);

    // CW cycle, x4 counts every transition with 19-edge latency.
    b4 = ena4_cyc.size(); b1 = ena1_cyc.size();
    for (int k = 0; k < 4; k++) hold(cw[k], 40, chgs[k]);
    check("cw_cnt4", ena4_cyc.size() - b4, 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("cw_lat4_%0d", k), q4_cyc(b4 + k) - chgs[k], 19);
      if (b4 + k < ena4_dir.size()) check($sformatf("cw_dir4_%0d", k), ena4_dir[b4 + k], 1'b1);
    end
    check("cw_cnt1", ena1_cyc.size() - b1, 1);
    check("cw_lat1", q1_cyc(b1) - chgs[3], 19);
    check("cw_wide4", wide4, 0);

    // CCW cycle, per-detent instance strobes once on entry to 00.
    b4 = ena4_cyc.size(); b1 = ena1_cyc.size();
    for (int k = 0; k < 4; k++) hold(ccw[k], 40, chgs[k]);
    check("ccw_cnt1", ena1_cyc.size() - b1, 1);
    check("ccw_lat1", q1_cyc(b1) - chgs[3], 19);
    if (b1 < ena1_dir.size()) begin
      check("ccw_dir1", ena1_dir[b1], 1'b0);
      check("ccw_st1", ena1_st[b1], 2'b00);
    end
    check("ccw_cnt4", ena4_cyc.size() - b4, 4);
    check("ccw_dir4", dir4, 1'b0);

    // Short glitch on a: filtered away.
    e4 = n_ena4; e1 = n_ena1; ee4 = n_err4;
    hold(2'b10, 10, chg);
    hold(2'b00, 40, chg);
    check("glitch_ena4", n_ena4 - e4, 0);
    check("glitch_ena1", n_ena1 - e1, 0);
    check("glitch_err4", n_err4 - ee4, 0);
    check("glitch_state", st4, 2'b00);

    // Bounce then settle at 10: exactly one (down) strobe.
    e4 = n_ena4; b4 = ena4_cyc.size();
    for (int k = 0; k < 4; k++) begin
      hold(2'b10, 5, chg);
      hold(2'b00, 5, chg);
    end
    hold(2'b10, 40, chg);
    check("bounce_ena4", n_ena4 - e4, 1);
    check("bounce_lat4", q4_cyc(b4) - chg, 19);
    check("bounce_dir4", dir4, 1'b0);
    check("bounce_state", st4, 2'b10);

    // Back to 00 (up), then 00 -> 11 jump: err, dir holds at 1.
    hold(2'b00, 40, chg);
    check("up_dir4", dir4, 1'b1);
    e4 = n_ena4; ee4 = n_err4;
    hold(2'b11, 40, chg);
    check("jump2_err4", n_err4 - ee4, 1);
    check("jump2_ena4", n_ena4 - e4, 0);
    check("jump2_dir4", dir4, 1'b1);
    check("jump2_state", st4, 2'b11);

    // Reset while b's debounce counter sits at 8.
    {a, b} = 2'b10;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_ena", ena4, 1'b0);
    check("mid_rst_err", err4, 1'b0);
    check("mid_rst_dir", dir4, 1'b0);
    check("mid_rst_state", st4, 2'b00);
    repeat (3) @(negedge clk);
    e4 = n_ena4; e1 = n_ena1; ee4 = n_err4; ee1 = n_err1;
    reset = 1'b1;
    repeat (100) @(negedge clk);
    check("rerun_ena4", n_ena4 - e4, 0);
    check("rerun_ena1", n_ena1 - e1, 0);
    check("rerun_err4", n_err4 - ee4, 0);
    check("rerun_err1", n_err1 - ee1, 0);
    check("rerun_state", st4, 2'b10);

    // Eight CW detents into the up/down counter.
    hold(2'b00, 40, chg);
    base_ud = ud_count;
    for (int d = 0; d < 8; d++) begin
      for (int k = 0; k < 4; k++) hold(cw[k], 25, chg);
    end
    check("ud_count", ud_count - base_ud, 8);
    check("final_wide", wide4 + wide1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
